branch_judge_unit: RTL and testbench

Parametrised, registered branch-decision unit for the control path. It holds the processor flag register (S, Z, C, V) with write-through forwarding and decodes a 16-entry condition set, whose codes 0–3 keep the legacy EQ/LT/LE/NE meaning. It adds a hardware loop counter (decrement-and-branch) and a configurable branch shadow that suppresses decisions after a taken branch. It sits between the decoder and the PC register and produces a one-cycle-latency `pc_load_out` pulse.

---
 rtl/branch_judge_unit.sv | 143 ++++++++++++++
 tb/tb_branch_judge_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_judge_unit.sv
// Branch decision unit: flag register with same-cycle forwarding, 16-way
// condition decode, hardware loop counter and a post-branch shadow that
// masks requests for a fixed number of cycles after a taken decision.
// The taken decision is registered into a one-cycle pc_load_out pulse.
module branch_judge_unit #(
    parameter int               OP_W      = 3,
    parameter int               CNT_W     = 16,
    parameter logic [OP_W-1:0]  OP_BRANCH = 3'b111,
    parameter logic [OP_W-1:0]  OP_JUMP   = 3'b100,
    parameter logic [OP_W-1:0]  OP_LOOP   = 3'b101,
    parameter int               SHADOW    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pc_load_in,
    input  logic [OP_W-1:0]  op2,
    input  logic [3:0]       cond,
    input  logic [3:0]       flag_in,
    input  logic             flag_we,
    input  logic [CNT_W-1:0] cnt_data,
    input  logic             cnt_we,
    output logic             pc_load_out,
    output logic [3:0]       flags_q,
    output logic [CNT_W-1:0] loop_cnt,
    output logic             shadow_active
);

    // Shadow reload value; SHADOW is limited to 0..7 so three bits suffice.
    localparam logic [2:0] SHADOW_LD = 3'(SHADOW);

    logic [3:0]       flags_d;
    logic [CNT_W-1:0] loop_cnt_q;
    logic [CNT_W-1:0] loop_cnt_d;
    logic [2:0]       shadow_q;
    logic [2:0]       shadow_d;
    logic             pc_load_q;
    logic             pc_load_d;

    logic [3:0]       eff_flags;
    logic             flag_s;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;
    logic             flag_n;
    logic             cond_hit;
    logic             eval_en;
    logic             take;
    logic             loop_dec;

    // Forward incoming ALU flags so a compare and branch can share a cycle.
    always_comb begin
        eff_flags = flag_we ? flag_in : flags_q;
        flag_s    = eff_flags[3];
        flag_z    = eff_flags[2];
        flag_c    = eff_flags[1];
        flag_v    = eff_flags[0];
        flag_n    = flag_s ^ flag_v;
    end

    // Condition decode; codes 0-3 keep the legacy EQ/LT/LE/NE meaning.
    always_comb begin
        cond_hit = 1'b0;
        case (cond)
            4'd0:    cond_hit = flag_z;
            4'd1:    cond_hit = flag_n;
            4'd2:    cond_hit = flag_z | flag_n;
            4'd3:    cond_hit = ~flag_z;
            4'd4:    cond_hit = ~flag_n;
            4'd5:    cond_hit = ~flag_z & ~flag_n;
            4'd6:    cond_hit = flag_c;
            4'd7:    cond_hit = ~flag_c;
            4'd8:    cond_hit = flag_s;
            4'd9:    cond_hit = ~flag_s;
            4'd10:   cond_hit = flag_v;
            4'd11:   cond_hit = ~flag_v;
            4'd12:   cond_hit = flag_c & ~flag_z;
            4'd13:   cond_hit = ~flag_c | flag_z;
            4'd14:   cond_hit = 1'b1;
            default: cond_hit = 1'b0;
        endcase
    end

    // Branch decision; only evaluated on a request outside the shadow window.
    always_comb begin
        eval_en  = pc_load_in && (shadow_q == 3'd0);
        take     = 1'b0;
        loop_dec = 1'b0;
        if (eval_en) begin
            case (op2)
                OP_BRANCH: take = cond_hit;
                OP_JUMP:   take = 1'b1;
                OP_LOOP: begin
                    if (loop_cnt_q != '0) begin
                        take     = 1'b1;
                        loop_dec = 1'b1;
                    end
                end
                default:   take = 1'b0;
            endcase
        end
    end

    // Next-state for flags, loop counter (load beats decrement) and shadow.
    always_comb begin
        flags_d = flag_we ? flag_in : flags_q;

        loop_cnt_d = loop_cnt_q;
        if (cnt_we) begin
            loop_cnt_d = cnt_data;
        end else if (loop_dec) begin
            loop_cnt_d = loop_cnt_q - 1'b1;
        end

        shadow_d = shadow_q;
        if (take) begin
            shadow_d = SHADOW_LD;
        end else if (shadow_q != 3'd0) begin
            shadow_d = shadow_q - 3'd1;
        end

        pc_load_d = take;
    end

    // State registers; reset overrides every same-cycle write and decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q    <= 4'b0000;
            loop_cnt_q <= '0;
            shadow_q   <= 3'd0;
            pc_load_q  <= 1'b0;
        end else begin
            flags_q    <= flags_d;
            loop_cnt_q <= loop_cnt_d;
            shadow_q   <= shadow_d;
            pc_load_q  <= pc_load_d;
        end
    end

    assign pc_load_out   = pc_load_q;
    assign loop_cnt      = loop_cnt_q;
    assign shadow_active = (shadow_q != 3'd0);

endmodule

// File: tb/tb_branch_judge_unit.sv
// Scoreboard bench for branch_judge_unit (instance built with SHADOW=2).
// Each stimulus step pushes the expected post-edge outputs into a queue;
// a monitor pops one entry per cycle on the falling edge and compares.
module tb_branch_judge_unit;

    localparam logic [2:0] OP_BR   = 3'b111;
    localparam logic [2:0] OP_JMP  = 3'b100;
    localparam logic [2:0] OP_LP   = 3'b101;
    localparam logic [2:0] OP_NONE = 3'b000;

    logic        clk;
    logic        rst;
    logic        pc_load_in;
    logic [2:0]  op2;
    logic [3:0]  cond;
    logic [3:0]  flag_in;
    logic        flag_we;
    logic [15:0] cnt_data;
    logic        cnt_we;
    logic        pc_load_out;
    logic [3:0]  flags_q;
    logic [15:0] loop_cnt;
    logic        shadow_active;

    typedef struct packed {
        logic        pc;
        logic [3:0]  fl;
        logic [15:0] lc;
        logic        sa;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    branch_judge_unit #(
        .OP_W(3), .CNT_W(16),
        .OP_BRANCH(3'b111), .OP_JUMP(3'b100), .OP_LOOP(3'b101),
        .SHADOW(2)
    ) dut (
        .clk(clk), .rst(rst), .pc_load_in(pc_load_in), .op2(op2),
        .cond(cond), .flag_in(flag_in), .flag_we(flag_we),
        .cnt_data(cnt_data), .cnt_we(cnt_we),
        .pc_load_out(pc_load_out), .flags_q(flags_q),
        .loop_cnt(loop_cnt), .shadow_active(shadow_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference condition table written straight from the decode list.
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic s, z, cy, v, n;
        s = f[3]; z = f[2]; cy = f[1]; v = f[0]; n = s ^ v;
        case (c)
            4'd0:  return z;
            4'd1:  return n;
            4'd2:  return z || n;
            4'd3:  return !z;
            4'd4:  return !n;
            4'd5:  return !z && !n;
            4'd6:  return cy;
            4'd7:  return !cy;
            4'd8:  return s;
            4'd9:  return !s;
            4'd10: return v;
            4'd11: return !v;
            4'd12: return cy && !z;
            4'd13: return !cy || z;
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic r, input logic pl, input logic [2:0] op,
                        input logic [3:0] cd, input logic [3:0] fin, input logic fwe,
                        input logic [15:0] cdat, input logic cwe,
                        input logic e_pc, input logic [3:0] e_fl,
                        input logic [15:0] e_lc, input logic e_sa);
        exp_t e;
        @(negedge clk);
        #1;
        rst = r; pc_load_in = pl; op2 = op; cond = cd;
        flag_in = fin; flag_we = fwe; cnt_data = cdat; cnt_we = cwe;
        e.pc = e_pc; e.fl = e_fl; e.lc = e_lc; e.sa = e_sa;
        exp_q.push_back(e);
        step_no++;
    endtask

    task automatic idle(input logic [3:0] e_fl, input logic [15:0] e_lc, input logic e_sa);
        step(1'b0, 1'b0, OP_NONE, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, e_fl, e_lc, e_sa);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, OP_JMP, 4'd14, 4'hF, 1'b1, 16'd9, 1'b1, 1'b0, 4'd0, 16'd0, 1'b0);
    endtask

    // Monitor: one scoreboard entry per cycle, sampled away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if (pc_load_out !== e.pc) begin
                n_fail++;
                $display("FAIL pc_load_out vec %0d: got %b want %b", n_vec, pc_load_out, e.pc);
            end
            if (flags_q !== e.fl) begin
                n_fail++;
                $display("FAIL flags_q vec %0d: got %b want %b", n_vec, flags_q, e.fl);
            end
            if (loop_cnt !== e.lc) begin
                n_fail++;
                $display("FAIL loop_cnt vec %0d: got %0d want %0d", n_vec, loop_cnt, e.lc);
            end
            if (shadow_active !== e.sa) begin
                n_fail++;
                $display("FAIL shadow_active vec %0d: got %b want %b", n_vec, shadow_active, e.sa);
            end
        end
    end

    initial begin
        logic t;
        rst = 1'b1; pc_load_in = 1'b0; op2 = '0; cond = '0;
        flag_in = '0; flag_we = 1'b0; cnt_data = '0; cnt_we = 1'b0;

        // Reset with a jump and writes pending: all outputs must stay zero.
        do_reset();
        do_reset();

        // Forwarded Z drives an EQ branch in the same cycle as the flag write.
        step(1'b0, 1'b1, OP_BR, 4'd0, 4'b0100, 1'b1, 16'd0, 1'b0, 1'b1, 4'b0100, 16'd0, 1'b1);
        idle(4'b0100, 16'd0, 1'b1);
        idle(4'b0100, 16'd0, 1'b0);
        // Stored flags (no write) used: NE with Z set -> not taken.
        step(1'b0, 1'b1, OP_BR, 4'd3, 4'b0000, 1'b0, 16'd0, 1'b0, 1'b0, 4'b0100, 16'd0, 1'b0);
        $display("section reset/flags queued, step %0d", step_no);

        // Full condition sweep; two idle cycles let the shadow drain.
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                t = ref_cond(4'(c), 4'(f));
                step(1'b0, 1'b1, OP_BR, 4'(c), 4'(f), 1'b1, 16'd0, 1'b0, t, 4'(f), 16'd0, t);
                idle(4'(f), 16'd0, t);
                idle(4'(f), 16'd0, 1'b0);
            end
            // Jump is always taken, an undefined opcode never is.
            step(1'b0, 1'b1, OP_JMP, 4'd15, 4'(f), 1'b1, 16'd0, 1'b0, 1'b1, 4'(f), 16'd0, 1'b1);
            idle(4'(f), 16'd0, 1'b1);
            idle(4'(f), 16'd0, 1'b0);
            step(1'b0, 1'b1, OP_NONE, 4'd14, 4'(f), 1'b1, 16'd0, 1'b0, 1'b0, 4'(f), 16'd0, 1'b0);
            step(1'b0, 1'b1, 3'b110, 4'd14, 4'(f), 1'b1, 16'd0, 1'b0, 1'b0, 4'(f), 16'd0, 1'b0);
        end
        $display("section condition sweep queued, step %0d", step_no);

        // Loop count-down from 3; loop requests inside the shadow do nothing.
        do_reset();
        step(1'b0, 1'b0, OP_NONE, 4'd0, 4'd0, 1'b0, 16'd3, 1'b1, 1'b0, 4'd0, 16'd3, 1'b0);
        for (int i = 2; i >= 0; i--) begin
            step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd0, 16'(i), 1'b1);
            step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'(i), 1'b1);
            step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'(i), 1'b0);
        end
        step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        $display("section loop count-down queued, step %0d", step_no);

        // Counter load collides with a loop decision: load wins, decision uses old value.
        step(1'b0, 1'b0, OP_NONE, 4'd0, 4'd0, 1'b0, 16'd5, 1'b1, 1'b0, 4'd0, 16'd5, 1'b0);
        step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd10, 1'b1, 1'b1, 4'd0, 16'd10, 1'b1);
        idle(4'd0, 16'd10, 1'b1);
        idle(4'd0, 16'd10, 1'b0);
        do_reset();
        step(1'b0, 1'b1, OP_LP, 4'd0, 4'd0, 1'b0, 16'd10, 1'b1, 1'b0, 4'd0, 16'd10, 1'b0);
        $display("section counter collision queued, step %0d", step_no);

        // Four consecutive jumps with SHADOW=2: pulses on the 1st and 4th.
        do_reset();
        step(1'b0, 1'b1, OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b1);
        step(1'b0, 1'b1, OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b1);
        step(1'b0, 1'b1, OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b0, 4'd0, 16'd0, 1'b0);
        step(1'b0, 1'b1, OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 4'd0, 16'd0, 1'b1);
        idle(4'd0, 16'd0, 1'b1);
        idle(4'd0, 16'd0, 1'b0);
        $display("section shadow queued, step %0d", step_no);

        // Reset while the loop counter holds 7 and the shadow is running.
        step(1'b0, 1'b0, OP_NONE, 4'd0, 4'b1010, 1'b1, 16'd7, 1'b1, 1'b0, 4'b1010, 16'd7, 1'b0);
        step(1'b0, 1'b1, OP_JMP, 4'd0, 4'd0, 1'b0, 16'd0, 1'b0, 1'b1, 4'b1010, 16'd7, 1'b1);
        do_reset();
        idle(4'd0, 16'd0, 1'b0);
        $display("section reset mid-operation queued, step %0d", step_no);

        // Let the monitor drain the queue, bounded by a few cycles.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Global time limit so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
